key_event_decoder: RTL and testbench

//  - Consumes the debounced key level from key_debounce.
//  - Classifies each key gesture: short press, long press, or double click.
//  - Emits exactly one single-cycle pulse per classified gesture.
//  - Sits between key_debounce and the beep/LED pattern logic in the key/beep top level.

---
 rtl/key_event_pkg.sv | 18 +
 rtl/key_edge_detect.sv | 21 ++
 rtl/key_event_decoder.sv | 141 ++++++++++++++
 tb/tb_key_event_decoder.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_event_pkg.sv
// rtl/key_event_pkg.sv - FSM state encodings and default timing constants for key_event_decoder
package key_event_pkg;

  typedef logic [2:0] key_state_t;

  localparam key_state_t IDLE      = 3'd0;
  localparam key_state_t PRESS1    = 3'd1;
  localparam key_state_t LONG_HOLD = 3'd2;
  localparam key_state_t WAIT_2ND  = 3'd3;
  localparam key_state_t PRESS2    = 3'd4;

  // Defaults assume a 50 MHz sys_clk: 1 s long press, 300 ms double-click window, 200 ms repeat
  localparam int         CNT_W_DEF  = 26;
  localparam logic [25:0] T_LONG_DEF = 26'd50_000_000;
  localparam logic [25:0] T_DBL_DEF  = 26'd15_000_000;
  localparam logic [25:0] T_RPT_DEF  = 26'd10_000_000;

endpackage

// File: rtl/key_edge_detect.sv
// rtl/key_edge_detect.sv - registers the debounced key and flags press/release edges (key is active low)
module key_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic key_in,
  output logic key_press,
  output logic key_release
);

  logic key_d;

  // Resetting to 1 makes a key already held at reset release look like a fresh press
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) key_d <= 1'b1;
    else        key_d <= key_in;
  end

  assign key_press   = key_d & ~key_in;
  assign key_release = ~key_d & key_in;

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies key gestures into short/long/double-click pulses
// Optional auto-repeat while long-held is enabled by defining KEY_REPEAT_EN.
module key_event_decoder
  import key_event_pkg::*;
#(
  parameter int               CNT_W  = CNT_W_DEF,
  parameter logic [CNT_W-1:0] T_LONG = CNT_W'(T_LONG_DEF),
  parameter logic [CNT_W-1:0] T_DBL  = CNT_W'(T_DBL_DEF),
  parameter logic [CNT_W-1:0] T_RPT  = CNT_W'(T_RPT_DEF)
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_filter,
  output logic short_press,
  output logic long_press,
  output logic double_click,
  output logic key_repeat,
  output logic key_busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = T_LONG - CNT_W'(1);
  localparam logic [CNT_W-1:0] DBL_LAST  = T_DBL - CNT_W'(1);

  if (T_LONG < CNT_W'(2) || T_DBL < CNT_W'(2) || T_RPT < CNT_W'(2)) begin : g_param_check
    $error("key_event_decoder: T_LONG, T_DBL and T_RPT must all be >= 2");
  end

  logic key_press;
  logic key_release;

  key_edge_detect u_edge (
    .clk         (sys_clk),
    .rst_n       (sys_rst_n),
    .key_in      (key_filter),
    .key_press   (key_press),
    .key_release (key_release)
  );

  key_state_t       state;
  key_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             short_nxt;
  logic             long_nxt;
  logic             dbl_nxt;
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] RPT_LAST = T_RPT - CNT_W'(1);
  logic rpt_nxt;
`endif

  // Key edges are tested before timeouts so an edge always wins a same-cycle tie
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CNT_W'(1);
    short_nxt = 1'b0;
    long_nxt  = 1'b0;
    dbl_nxt   = 1'b0;
`ifdef KEY_REPEAT_EN
    rpt_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (key_press) state_nxt = PRESS1;
      end
      PRESS1: begin
        if (key_release) begin
          state_nxt = WAIT_2ND;
          cnt_nxt   = '0;
        end else if (cnt == LONG_LAST) begin
          state_nxt = LONG_HOLD;
          cnt_nxt   = '0;
          long_nxt  = 1'b1;
        end
      end
      LONG_HOLD: begin
        if (key_release) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
`ifdef KEY_REPEAT_EN
        else if (cnt == RPT_LAST) begin
          cnt_nxt = '0;
          rpt_nxt = 1'b1;
        end
`endif
      end
      WAIT_2ND: begin
        if (key_press) begin
          state_nxt = PRESS2;
          cnt_nxt   = '0;
        end else if (cnt == DBL_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          short_nxt = 1'b1;
        end
      end
      PRESS2: begin
        // No timeout here: however long the second hold, its release is a double click
        cnt_nxt = cnt;
        if (key_release) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          dbl_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_click <= 1'b0;
      key_busy     <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      short_press  <= short_nxt;
      long_press   <= long_nxt;
      double_click <= dbl_nxt;
      key_busy     <= (state_nxt != IDLE);
    end
  end

`ifdef KEY_REPEAT_EN
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) key_repeat <= 1'b0;
    else            key_repeat <= rpt_nxt;
  end
`else
  assign key_repeat = 1'b0;
`endif

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - directed self-checking bench for key_event_decoder (T_LONG=20, T_DBL=8, T_RPT=5)
module tb_key_event_decoder;

  logic sys_clk;
  logic sys_rst_n;
  logic key_filter;
  logic short_press;
  logic long_press;
  logic double_click;
  logic key_repeat;
  logic key_busy;

  int tests;
  int fails;
  int cyc;

  int n_sp, t_sp, n_lp, t_lp, n_dc, t_dc, n_rp, t_rp_first, t_rp_last;
  int n_multi;

  key_event_decoder #(
    .T_LONG (26'd20),
    .T_DBL  (26'd8),
    .T_RPT  (26'd5)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .key_filter   (key_filter),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_click (double_click),
    .key_repeat   (key_repeat),
    .key_busy     (key_busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Pulse log sampled mid-cycle; tasks compare it against hand-computed cycle numbers
  initial n_multi = 0;
  always @(negedge sys_clk) begin
    if (short_press)  begin n_sp++; t_sp = cyc; end
    if (long_press)   begin n_lp++; t_lp = cyc; end
    if (double_click) begin n_dc++; t_dc = cyc; end
    if (key_repeat) begin
      if (n_rp == 0) t_rp_first = cyc;
      n_rp++;
      t_rp_last = cyc;
    end
    if (int'(short_press) + int'(long_press) + int'(double_click) + int'(key_repeat) > 1) n_multi++;
  end

  task automatic clear_mon();
    n_sp = 0; t_sp = -1; n_lp = 0; t_lp = -1; n_dc = 0; t_dc = -1;
    n_rp = 0; t_rp_first = -1; t_rp_last = -1;
  endtask

  // Drive key level v for n clock samples; t_edge is the cycle of the first sampling edge
  task automatic key_hold(input logic v, input int n, output int t_edge);
    @(negedge sys_clk);
    key_filter = v;
    t_edge = cyc + 1;
    repeat (n - 1) @(negedge sys_clk);
  endtask

  task automatic test_reset();
    logic [4:0] outs;
    sys_rst_n  = 1'b0;
    key_filter = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      key_filter = ~key_filter;
      outs = {short_press, long_press, double_click, key_repeat, key_busy};
      tests++;
      if (outs !== 5'b0) begin
        fails++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 00000", i, outs);
      end
    end
    clear_mon();
    @(negedge sys_clk);
    key_filter = 1'b1;
    sys_rst_n  = 1'b1;
    repeat (6) @(negedge sys_clk);
    tests++;
    if (key_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_release_busy: got %b expected 0", key_busy);
    end
    tests++;
    if (n_sp + n_lp + n_dc + n_rp !== 0) begin
      fails++;
      $display("FAIL reset_release_pulses: got %0d expected 0", n_sp + n_lp + n_dc + n_rp);
    end
  endtask

  task automatic test_short_press();
    int tp, tr;
    clear_mon();
    key_hold(1'b0, 5, tp);
    tests++;
    if (key_busy !== 1'b1) begin
      fails++;
      $display("FAIL short_busy_held: got %b expected 1", key_busy);
    end
    key_hold(1'b1, 15, tr);
    tests++;
    if (n_sp !== 1 || t_sp !== tr + 8) begin
      fails++;
      $display("FAIL short_pulse: got count %0d at %0d expected count 1 at %0d", n_sp, t_sp, tr + 8);
    end
    tests++;
    if (n_lp + n_dc + n_rp !== 0) begin
      fails++;
      $display("FAIL short_other_pulses: got %0d expected 0", n_lp + n_dc + n_rp);
    end
    tests++;
    if (key_busy !== 1'b0) begin
      fails++;
      $display("FAIL short_busy_after: got %b expected 0", key_busy);
    end
  endtask

  task automatic test_long_press();
    int tp, tr;
    clear_mon();
    key_hold(1'b0, 41, tp);
    tests++;
    if (key_busy !== 1'b1) begin
      fails++;
      $display("FAIL long_busy_held: got %b expected 1", key_busy);
    end
    key_hold(1'b1, 1, tr);
    @(negedge sys_clk);
    tests++;
    if (key_busy !== 1'b0) begin
      fails++;
      $display("FAIL long_busy_release: got %b expected 0", key_busy);
    end
    repeat (12) @(negedge sys_clk);
    tests++;
    if (n_lp !== 1 || t_lp !== tp + 20) begin
      fails++;
      $display("FAIL long_pulse: got count %0d at %0d expected count 1 at %0d", n_lp, t_lp, tp + 20);
    end
    tests++;
    if (n_sp + n_dc !== 0) begin
      fails++;
      $display("FAIL long_no_short: got %0d expected 0", n_sp + n_dc);
    end
`ifdef KEY_REPEAT_EN
    tests++;
    if (n_rp !== 4 || t_rp_first !== tp + 25 || t_rp_last !== tp + 40) begin
      fails++;
      $display("FAIL long_repeat: got %0d pulses first %0d last %0d expected 4 first %0d last %0d",
               n_rp, t_rp_first, t_rp_last, tp + 25, tp + 40);
    end
`else
    tests++;
    if (n_rp !== 0) begin
      fails++;
      $display("FAIL long_repeat_off: got %0d expected 0", n_rp);
    end
`endif
  endtask

  task automatic test_double_click();
    int t, tr2;
    clear_mon();
    key_hold(1'b0, 3, t);
    key_hold(1'b1, 4, t);
    key_hold(1'b0, 3, t);
    key_hold(1'b1, 12, tr2);
    tests++;
    if (n_dc !== 1 || t_dc !== tr2) begin
      fails++;
      $display("FAIL double_pulse: got count %0d at %0d expected count 1 at %0d", n_dc, t_dc, tr2);
    end
    tests++;
    if (n_sp + n_lp !== 0) begin
      fails++;
      $display("FAIL double_no_short: got %0d expected 0", n_sp + n_lp);
    end
  endtask

  task automatic test_boundary_long();
    int tp, tr;
    clear_mon();
    key_hold(1'b0, 20, tp);
    key_hold(1'b1, 12, tr);
    tests++;
    if (n_lp !== 0) begin
      fails++;
      $display("FAIL bound_long_19: got %0d long pulses expected 0", n_lp);
    end
    tests++;
    if (n_sp !== 1 || t_sp !== tr + 8) begin
      fails++;
      $display("FAIL bound_long_short: got count %0d at %0d expected count 1 at %0d", n_sp, t_sp, tr + 8);
    end
    clear_mon();
    key_hold(1'b0, 21, tp);
    key_hold(1'b1, 12, tr);
    tests++;
    if (n_lp !== 1 || t_lp !== tp + 20 || n_sp !== 0) begin
      fails++;
      $display("FAIL bound_long_20: got long %0d at %0d short %0d expected long 1 at %0d short 0",
               n_lp, t_lp, n_sp, tp + 20);
    end
  endtask

  task automatic test_boundary_double();
    int t, tr2;
    clear_mon();
    key_hold(1'b0, 3, t);
    key_hold(1'b1, 8, t);
    key_hold(1'b0, 3, t);
    key_hold(1'b1, 12, tr2);
    tests++;
    if (n_dc !== 1 || t_dc !== tr2) begin
      fails++;
      $display("FAIL bound_dbl_pulse: got count %0d at %0d expected count 1 at %0d", n_dc, t_dc, tr2);
    end
    tests++;
    if (n_sp !== 0) begin
      fails++;
      $display("FAIL bound_dbl_no_short: got %0d expected 0", n_sp);
    end
  endtask

  task automatic test_reset_mid_gesture();
    int t, tr;
    clear_mon();
    key_hold(1'b0, 3, t);
    key_hold(1'b1, 3, t);
    tests++;
    if (key_busy !== 1'b1) begin
      fails++;
      $display("FAIL mid_busy_wait: got %b expected 1", key_busy);
    end
    @(negedge sys_clk);
    sys_rst_n = 1'b0;
    repeat (2) @(negedge sys_clk);
    tests++;
    if (key_busy !== 1'b0) begin
      fails++;
      $display("FAIL mid_busy_reset: got %b expected 0", key_busy);
    end
    sys_rst_n = 1'b1;
    repeat (15) @(negedge sys_clk);
    tests++;
    if (n_sp + n_lp + n_dc + n_rp !== 0) begin
      fails++;
      $display("FAIL mid_no_pulse: got %0d expected 0", n_sp + n_lp + n_dc + n_rp);
    end
    clear_mon();
    key_hold(1'b0, 4, t);
    key_hold(1'b1, 15, tr);
    tests++;
    if (n_sp !== 1 || t_sp !== tr + 8) begin
      fails++;
      $display("FAIL mid_fresh_short: got count %0d at %0d expected count 1 at %0d", n_sp, t_sp, tr + 8);
    end
  endtask

  task automatic test_one_hot_pulses();
    tests++;
    if (n_multi !== 0) begin
      fails++;
      $display("FAIL one_hot_pulses: got %0d overlapping cycles expected 0", n_multi);
    end
  endtask

  initial begin
    tests      = 0;
    fails      = 0;
    sys_rst_n  = 1'b0;
    key_filter = 1'b1;
    test_reset();
    test_short_press();
    test_long_press();
    test_double_click();
    test_boundary_long();
    test_boundary_double();
    test_reset_mid_gesture();
    test_one_hot_pulses();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
